vdp_cpu_port_bridge: RTL

Parametrised Z80 I/O bridge between the host bus and the VDP register interface, replacing the single-slot CS latch in the top level. It decodes the VDP port window, filters and synchronises the strobes into `clk_w`, and buffers writes in a FIFO so back-to-back OUTs are not lost. Reads are ordered behind pending writes and stretch the host cycle with `wait_n`. It sits between the top-level pins (`cd`, `rd_n`, `wr_n`, `iorq_n`, `A7..A2`) and the VDP `REQ/ACK/WRT/ADR/DBI/DBO` port.

---
 rtl/vdp_cpu_port_bridge.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/vdp_cpu_port_bridge.sv
// Z80 I/O bridge to the VDP register port. It decodes the port window, synchronises and
// filters the host strobes, queues writes in a FIFO, and orders reads behind those writes.
module vdp_cpu_port_bridge #(
  parameter int unsigned         DEC_BITS   = 4,
  parameter logic [DEC_BITS-1:0] DEC_BASE   = DEC_BITS'(4'b1001),
  parameter int unsigned         PORT_BITS  = 2,
  parameter int unsigned         FILTER_LEN = 3,
  parameter int unsigned         FIFO_DEPTH = 4,
  parameter int unsigned         ADR_W      = 16
) (
  input  logic                          clk_w,
  input  logic                          reset_n_w,
  input  logic [DEC_BITS-1:0]           a_dec,
  input  logic [PORT_BITS-1:0]          a_port,
  input  logic                          iorq_n,
  input  logic                          rd_n,
  input  logic                          wr_n,
  input  logic [7:0]                    cd_in,
  output logic [7:0]                    cd_out,
  output logic                          cd_oe,
  output logic                          csw_n,
  output logic                          csr_n,
  output logic                          wait_n,
  output logic                          vdp_req,
  output logic                          vdp_wrt,
  output logic [ADR_W-1:0]              vdp_adr,
  output logic [7:0]                    vdp_dbo,
  input  logic [7:0]                    vdp_dbi,
  input  logic                          vdp_ack,
  output logic                          ovf,
  input  logic                          ovf_clr,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;
  localparam int unsigned ENT_W = PORT_BITS + 8;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {ST_IDLE, ST_WR, ST_RD} state_t;

  logic                          cs;
  logic [1:0]                    strb_m, strb_s;   // [0] write select, [1] read select
  logic [PORT_BITS-1:0]          port_m, port_s;
  logic [7:0]                    data_m, data_s;
  logic [1:0]                    filt_q, filt_nxt;
  logic [1:0][CNT_W-1:0]         cnt_q, cnt_nxt;
  logic                          w_fall, r_fall, r_rise;
  logic [ENT_W-1:0]              mem [FIFO_DEPTH];
  logic [PTR_W-1:0]              wr_ptr, rd_ptr;
  logic [LVL_W-1:0]              level;
  logic                          full, empty, push, pop, rd_ack;
  logic [ENT_W-1:0]              head;
  logic                          rd_pend, rd_valid;
  logic [PORT_BITS-1:0]          rd_port;
  logic [7:0]                    rd_data;
  state_t                        state, state_nxt;
  logic                          req_nxt, wrt_nxt;
  logic [ADR_W-1:0]              adr_nxt;
  logic [7:0]                    dbo_nxt;

  // Host-side decode, deliberately combinational so the selects track the pins.
  assign cs         = (a_dec == DEC_BASE) & ~iorq_n;
  assign csw_n      = ~(cs & ~wr_n);
  assign csr_n      = ~(cs & ~rd_n);
  assign cd_oe      = ~csr_n;
  assign wait_n     = ~reset_n_w | csr_n | rd_valid;
  assign cd_out     = rd_data;
  assign fifo_level = level;

  // Two-flop synchronisers for strobes, port select and data.
  always_ff @(posedge clk_w or negedge reset_n_w) begin
    if (!reset_n_w) begin
      strb_m <= '1;
      strb_s <= '1;
      port_m <= '0;
      port_s <= '0;
      data_m <= '0;
      data_s <= '0;
    end else begin
      strb_m <= {csr_n, csw_n};
      strb_s <= strb_m;
      port_m <= a_port;
      port_s <= port_m;
      data_m <= cd_in;
      data_s <= data_m;
    end
  end

  // A filter flips only after FILTER_LEN consecutive samples disagree with it.
  always_comb begin
    filt_nxt = filt_q;
    cnt_nxt  = '0;
    for (int i = 0; i < 2; i++) begin
      if (strb_s[i] != filt_q[i]) begin
        if (cnt_q[i] == CNT_W'(FILTER_LEN - 1)) begin
          filt_nxt[i] = strb_s[i];
        end else begin
          cnt_nxt[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_w or negedge reset_n_w) begin
    if (!reset_n_w) begin
      filt_q <= '1;
      cnt_q  <= '0;
    end else begin
      filt_q <= filt_nxt;
      cnt_q  <= cnt_nxt;
    end
  end

  // Edges act on the cycle the filter flips; simultaneous read/write falls cancel.
  assign w_fall = filt_q[0] & ~filt_nxt[0] & filt_nxt[1];
  assign r_fall = filt_q[1] & ~filt_nxt[1] & filt_nxt[0];
  assign r_rise = ~filt_q[1] & filt_nxt[1];

  assign full   = (level == LVL_W'(FIFO_DEPTH));
  assign empty  = (level == '0);
  assign push   = w_fall & ~full;
  assign pop    = (state == ST_WR) & vdp_ack;
  assign rd_ack = (state == ST_RD) & vdp_ack;
  assign head   = mem[rd_ptr];

  always_ff @(posedge clk_w) begin
    if (push) mem[wr_ptr] <= {port_s, data_s};
  end

  always_ff @(posedge clk_w or negedge reset_n_w) begin
    if (!reset_n_w) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      level <= level + LVL_W'(1);
      else if (pop && !push) level <= level - LVL_W'(1);
      if (w_fall && full) ovf <= 1'b1;
      else if (ovf_clr)   ovf <= 1'b0;
    end
  end

  // Pending read request and the data returned to the host.
  always_ff @(posedge clk_w or negedge reset_n_w) begin
    if (!reset_n_w) begin
      rd_pend  <= 1'b0;
      rd_port  <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      if (r_fall) begin
        rd_pend <= 1'b1;
        rd_port <= port_s;
      end else if (rd_ack) begin
        rd_pend <= 1'b0;
      end
      if (rd_ack) rd_data <= vdp_dbi;
      if (r_rise)      rd_valid <= 1'b0;
      else if (rd_ack) rd_valid <= 1'b1;
    end
  end

  // Issue FSM: queued writes always drain before a pending read.
  always_comb begin
    state_nxt = state;
    req_nxt   = vdp_req;
    wrt_nxt   = vdp_wrt;
    adr_nxt   = vdp_adr;
    dbo_nxt   = vdp_dbo;
    unique case (state)
      ST_IDLE: begin
        if (!empty) begin
          state_nxt = ST_WR;
          req_nxt   = 1'b1;
          wrt_nxt   = 1'b1;
          adr_nxt   = ADR_W'(head[ENT_W-1:8]);
          dbo_nxt   = head[7:0];
        end else if (rd_pend) begin
          state_nxt = ST_RD;
          req_nxt   = 1'b1;
          wrt_nxt   = 1'b0;
          adr_nxt   = ADR_W'(rd_port);
        end
      end
      ST_WR, ST_RD: begin
        if (vdp_ack) begin
          state_nxt = ST_IDLE;
          req_nxt   = 1'b0;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        req_nxt   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_w or negedge reset_n_w) begin
    if (!reset_n_w) begin
      state   <= ST_IDLE;
      vdp_req <= 1'b0;
      vdp_wrt <= 1'b0;
      vdp_adr <= '0;
      vdp_dbo <= '0;
    end else begin
      state   <= state_nxt;
      vdp_req <= req_nxt;
      vdp_wrt <= wrt_nxt;
      vdp_adr <= adr_nxt;
      vdp_dbo <= dbo_nxt;
    end
  end

endmodule
